fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end between instruction memory and decode.
//  Owns the fetch PC and streams sequential requests to imem, up to DEPTH ahead.
//  Buffers {pc, instruction} pairs in a FIFO, so decode stalls and imem_wait no longer stall each other.
//  Flushes the FIFO and in-flight fetches on an EX-stage redirect (taken branch or jump).
// PARAMETERS
//  XLEN      32      address/instruction width
//  DEPTH     4       FIFO entries; power of two, >= 2
//  RESET_PC  32'h10  first fetch address after reset
// PORTS
//  clk              in   1     clock
//  reset_n          in   1     asynchronous active-low reset
//  redirect_valid   in   1     EX resolved a taken branch/jump this cycle
//  redirect_pc      in   XLEN  branch target
//  imem_address     out  XLEN  fetch address (combinational)
//  imem_enable      out  1     fetch request
//  imem_data        in   XLEN  instruction; valid the cycle after an accepted request
//  imem_wait        in   1     request presented this cycle is not accepted
//  out_valid        out  1     FIFO head valid
//  out_ready        in   1     decode consumes head
//  out_pc           out  XLEN  head PC
//  out_instruction  out  XLEN  head instruction
//  occupancy        out  $clog2(DEPTH+1)  entries held (debug/perf)
// BEHAVIOUR
//  Reset (async, reset_n=0): fetch_pc=RESET_PC; FIFO empty; no request in flight.
//   Outputs: out_valid=0, occupancy=0, imem_enable=0.
//   Release is synchronous: the first request is issued in the first clk after release.
//  Request:
//   accepted = imem_enable && !imem_wait.
//   imem_enable = (occupancy + inflight < DEPTH) || redirect_valid.
//   Credit check uses registered counts only; a pop in the same cycle frees no credit.
//   imem_address = redirect_valid ? redirect_pc : fetch_pc.
//   On accept: fetch_pc <= imem_address + 4; inflight <= 1.
//   Otherwise inflight <= 0 and fetch_pc holds.
//  Response:
//   Fixed 1-cycle latency: data for the request accepted in cycle N is on imem_data in cycle N+1.
//   Pushed to the FIFO with its PC, captured in N, unless dropped.
//  Handshake:
//   pop = out_valid && out_ready; the head is stable while out_valid && !out_ready.
//   Push and pop in the same cycle leave occupancy unchanged.
//   Empty: out_valid=0, and out_ready is ignored.
//   Full: cannot overflow, because the credit rule reserves a slot for every in-flight request.
//  Redirect (highest priority):
//   The FIFO is cleared (occupancy <= 0). The response arriving this cycle is dropped.
//   A pop in the same cycle has no effect.
//   A request to redirect_pc is issued in the same cycle.
//   If imem_wait is high, fetch_pc <= redirect_pc and the request retries next cycle.
//   The request in flight at the redirect is tagged stale; its response next cycle is dropped.
//   Mechanism: an epoch bit toggles on redirect; a response is kept only if its tag matches.
//  Back-to-back redirects: each overrides the previous; only the latest target's stream survives.
//  Wrap-around:
//   FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
//   fetch_pc wraps modulo 2^XLEN with no special handling.
//  Reset mid-operation: all state, including the epoch and the inflight flag, returns to reset values immediately.
// STRUCTURE
//  TYPES package: fetch_entry_t {logic [31:0] pc; logic [31:0] instruction;}.
//  Sub-module fetch_fifo (DEPTH, fetch_entry_t payload):
//   push, pop and clear inputs; head, occupancy and full outputs.
//  Request/credit/epoch logic lives in fetch_queue.
// TESTING
//  1. Reset release, out_ready=1, no waits:
//     imem_address 0x10,0x14,0x18... on consecutive cycles.
//     out_pc=0x10 with out_valid 2 cycles after release.
//  2. out_ready=0, DEPTH=4:
//     exactly 4 requests accepted, then imem_enable=0; occupancy=4.
//     Raise out_ready: one pop per cycle, PCs 0x10..0x1C in order, fetching resumes at 0x20.
//  3. imem_wait high 3 cycles at 0x14: imem_address holds 0x14; no duplicate or missing entries.
//  4. Redirect to 0x100 while 3 entries are queued and one is in flight:
//     occupancy -> 0; stale response dropped.
//     Next out_pc=0x100, then 0x104.
//  5. Redirect to 0x200 with imem_wait=1, then a redirect to 0x300 the next cycle:
//     only 0x300, 0x304... reach the output.
//  6. reset_n low mid-stream (async, between edges):
//     out_valid=0 and occupancy=0 immediately; after release, fetching restarts at 0x10.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_entry_t : {pc, instruction} pair held in the fetch FIFO
//   XLEN_W        : default address/instruction width
//   INSN_BYTES    : sequential fetch stride
package fetch_queue_pkg;

  localparam int XLEN_W = 32;
  localparam logic [XLEN_W-1:0] INSN_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, imem and decode-side signals of the fetch front end.
//   master : fetch_queue side (drives imem request and FIFO head)
//   slave  : environment side (EX redirect, imem, decode)
//   redirect_valid/redirect_pc : taken branch/jump from EX
//   imem_address/imem_enable   : fetch request, imem_wait stalls it
//   imem_data                  : instruction, one cycle after an accepted request
//   out_valid/out_ready/out_pc/out_instruction : FIFO head handshake to decode
//   occupancy                  : entries held
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = XLEN_W,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_address;
  logic            imem_enable;
  logic [XLEN-1:0] imem_data;
  logic            imem_wait;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instruction;
  logic [CW-1:0]   occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_data, imem_wait, out_ready,
    output imem_address, imem_enable, out_valid, out_pc, out_instruction, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_data, imem_wait, out_ready,
    input  imem_address, imem_enable, out_valid, out_pc, out_instruction, occupancy
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with synchronous clear.
//   clk, reset_n : clock, async active-low reset
//   push/push_data : enqueue (ignored when full unless a pop frees the slot)
//   pop          : dequeue head (ignored when empty)
//   clear        : drop all entries; wins over push and pop
//   head         : entry at the read pointer (valid while occupancy != 0)
//   occupancy    : entries held, full : occupancy == DEPTH
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output fetch_entry_t  head,
  output logic [CW-1:0] occupancy,
  output logic          full
);

  fetch_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (occupancy == CW'(DEPTH));
  assign do_pop  = pop && (occupancy != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // storage needs no reset: nothing is read until occupancy says so
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      occupancy <= occupancy + CW'(1);
      else if (do_pop && !do_push) occupancy <= occupancy - CW'(1);
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end between imem and decode.
//   Owns the fetch PC, issues sequential requests up to DEPTH ahead, buffers
//   {pc, instruction} pairs and flushes everything on an EX redirect.
//   clk, reset_n : clock, async active-low reset
//   bus (master) : redirect, imem request/response, decode handshake, occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_W,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h10
) (
  input logic           clk,
  input logic           reset_n,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;     // PC of the request now in flight
  logic            inflight;
  logic            epoch;
  logic            req_epoch;  // epoch the in-flight request was issued under
  logic            credit_ok, accepted, push, pop, full;
  logic [CW-1:0]   occupancy;
  fetch_entry_t    head, resp;

  // Registered counts only: a same-cycle pop frees nothing, so every
  // in-flight request always has a slot waiting for it.
  assign credit_ok = ({1'b0, occupancy} + (CW+1)'(inflight)) < (CW+1)'(DEPTH);

  // reset_n gate keeps the request low while reset is held; the first
  // request goes out in the cycle right after release.
  assign bus.imem_enable  = reset_n && (credit_ok || bus.redirect_valid);
  assign bus.imem_address = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
  assign accepted         = bus.imem_enable && !bus.imem_wait;

  // A redirect drops whatever arrives this cycle; the epoch tag also drops
  // any response that belongs to a stream issued before the last redirect.
  assign push = inflight && (req_epoch == epoch) && !bus.redirect_valid;
  assign pop  = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign resp = '{pc: req_pc, instruction: bus.imem_data};

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      epoch     <= 1'b0;
      req_epoch <= 1'b0;
    end else begin
      inflight <= accepted;
      if (bus.redirect_valid) epoch <= ~epoch;
      if (accepted) begin
        fetch_pc  <= bus.imem_address + INSN_BYTES;
        req_pc    <= bus.imem_address;
        req_epoch <= epoch ^ bus.redirect_valid;
      end else if (bus.redirect_valid) begin
        // target stalled by imem_wait: retry it next cycle
        fetch_pc <= bus.redirect_pc;
      end
    end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (resp),
    .pop       (pop),
    .clear     (bus.redirect_valid),
    .head      (head),
    .occupancy (occupancy),
    .full      (full)
  );

  assign bus.out_valid       = (occupancy != '0);
  assign bus.out_pc          = head.pc;
  assign bus.out_instruction = head.instruction;
  assign bus.occupancy       = occupancy;

  // the credit rule makes a push into a full FIFO without a pop impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus();

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: queue of entries, next fetch PC, and the one pending response
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc;
  bit           m_pend;
  logic [31:0]  m_pend_pc;

  // last sampled DUT outputs
  logic [31:0] s_addr, s_pc;
  bit          s_en, s_valid;
  int          s_occ;

  typedef struct {
    bit          do_rst;
    bit          rv;
    logic [31:0] rpc;
    bit          wt;
    bit          rdy;
    logic [31:0] e_addr;
    bit          e_en;
    bit          e_v;
    logic [31:0] e_pc;
    int          e_occ;
  } vec_t;

  vec_t vt[$];
  bit   tab_on = 0;
  vec_t tab_row;
  int   tab_idx;

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = RST_PC;
    m_pend = 0;
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 0;
    bus.redirect_pc    = '0;
    bus.imem_wait      = 0;
    bus.out_ready      = 0;
    bus.imem_data      = 32'hDEAD_BEEF;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_occupancy", 32'(bus.occupancy), 0);
    chk("rst_imem_enable", 32'(bus.imem_enable), 0);
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
  endtask

  // One clock: drive inputs, sample and check against the model (and the
  // table row if active), advance the model, clock, and answer imem.
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit wt, input bit rdy);
    bit          exp_en, exp_v, acc_act, push_m, pop_m;
    logic [31:0] exp_addr, addr_act;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_wait      = wt;
    bus.out_ready      = rdy;
    #1;
    s_addr = bus.imem_address; s_en = bus.imem_enable; s_valid = bus.out_valid;
    s_pc = bus.out_pc; s_occ = int'(bus.occupancy);
    exp_en   = (m_q.size() + (m_pend ? 1 : 0) < DEPTH) || rv;
    exp_addr = rv ? rpc : m_pc;
    exp_v    = (m_q.size() != 0);
    chk("imem_enable", 32'(s_en), 32'(exp_en));
    chk("imem_address", s_addr, exp_addr);
    chk("out_valid", 32'(s_valid), 32'(exp_v));
    chk("occupancy", 32'(s_occ), 32'(m_q.size()));
    if (exp_v) begin
      chk("out_pc", s_pc, m_q[0].pc);
      chk("out_instruction", bus.out_instruction, m_q[0].instruction);
    end
    if (tab_on) begin
      chk($sformatf("v%0d_addr", tab_idx), s_addr, tab_row.e_addr);
      chk($sformatf("v%0d_en", tab_idx), 32'(s_en), 32'(tab_row.e_en));
      chk($sformatf("v%0d_valid", tab_idx), 32'(s_valid), 32'(tab_row.e_v));
      chk($sformatf("v%0d_occ", tab_idx), 32'(s_occ), 32'(tab_row.e_occ));
      if (tab_row.e_v) chk($sformatf("v%0d_pc", tab_idx), s_pc, tab_row.e_pc);
    end
    acc_act  = bus.imem_enable && !wt;
    addr_act = bus.imem_address;
    push_m = m_pend && !rv;
    pop_m  = exp_v && rdy && !rv;
    if (rv) m_q.delete();
    else begin
      if (pop_m) void'(m_q.pop_front());
      if (push_m) m_q.push_back('{pc: m_pend_pc, instruction: insn_of(m_pend_pc)});
    end
    if (exp_en && !wt) begin
      m_pend = 1; m_pend_pc = exp_addr; m_pc = exp_addr + 32'd4;
    end else begin
      m_pend = 0;
      if (rv) m_pc = rpc;
    end
    @(posedge clk); #1;
    bus.imem_data = acc_act ? insn_of(addr_act) : $urandom();
  endtask

  task automatic add_vec(input bit r, input bit wt, input bit rdy, input logic [31:0] a,
                         input bit en, input bit v, input logic [31:0] pc, input int occ);
    vt.push_back('{do_rst: r, rv: 1'b0, rpc: 32'h0, wt: wt, rdy: rdy, e_addr: a,
                   e_en: en, e_v: v, e_pc: pc, e_occ: occ});
  endtask

  initial begin
    idle_inputs();
    // back-pressure from reset: 4 requests then stop; drain in order, resume at 0x20
    add_vec(1,0,0,32'h10,1,0,32'h0 ,0); add_vec(0,0,0,32'h14,1,0,32'h0 ,0);
    add_vec(0,0,0,32'h18,1,1,32'h10,1); add_vec(0,0,0,32'h1C,1,1,32'h10,2);
    add_vec(0,0,0,32'h20,0,1,32'h10,3); add_vec(0,0,0,32'h20,0,1,32'h10,4);
    add_vec(0,0,1,32'h20,0,1,32'h10,4); add_vec(0,0,1,32'h20,1,1,32'h14,3);
    add_vec(0,0,1,32'h24,1,1,32'h18,2); add_vec(0,0,1,32'h28,1,1,32'h1C,2);
    add_vec(0,0,1,32'h2C,1,1,32'h20,2);
    // free-running stream: first head two cycles after release
    add_vec(1,0,1,32'h10,1,0,32'h0 ,0); add_vec(0,0,1,32'h14,1,0,32'h0 ,0);
    add_vec(0,0,1,32'h18,1,1,32'h10,1); add_vec(0,0,1,32'h1C,1,1,32'h14,1);
    add_vec(0,0,1,32'h20,1,1,32'h18,1);
    // imem_wait for 3 cycles at 0x14: address holds, no duplicate entry
    add_vec(1,0,1,32'h10,1,0,32'h0 ,0); add_vec(0,1,1,32'h14,1,0,32'h0 ,0);
    add_vec(0,1,1,32'h14,1,1,32'h10,1); add_vec(0,1,1,32'h14,1,0,32'h0 ,0);
    add_vec(0,0,1,32'h14,1,0,32'h0 ,0); add_vec(0,0,1,32'h18,1,0,32'h0 ,0);
    add_vec(0,0,1,32'h1C,1,1,32'h14,1); add_vec(0,0,1,32'h20,1,1,32'h18,1);

    tab_on = 1;
    foreach (vt[i]) begin
      if (vt[i].do_rst) begin tab_on = 0; apply_reset(); tab_on = 1; end
      tab_idx = i; tab_row = vt[i];
      cycle(vt[i].rv, vt[i].rpc, vt[i].wt, vt[i].rdy);
    end
    tab_on = 0;

    // redirect with 3 queued + 1 in flight
    apply_reset();
    repeat (4) cycle(0, 0, 0, 0);
    chk("t4_pre_occ", 32'(s_occ), 2);
    cycle(1, 32'h100, 0, 0);
    chk("t4_redir_addr", s_addr, 32'h100);
    cycle(0, 0, 0, 0);
    chk("t4_occ_cleared", 32'(s_occ), 0);
    chk("t4_valid_cleared", 32'(s_valid), 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("t4_first_pc", s_pc, 32'h100);
    cycle(0, 0, 0, 1);
    chk("t4_second_pc", s_pc, 32'h104);

    // stalled redirect then a second redirect: only the latest stream survives
    apply_reset();
    repeat (3) cycle(0, 0, 0, 1);
    cycle(1, 32'h200, 1, 1);
    chk("t5_addr_200", s_addr, 32'h200);
    cycle(1, 32'h300, 0, 1);
    chk("t5_addr_300", s_addr, 32'h300);
    cycle(0, 0, 0, 1);
    chk("t5_empty", 32'(s_valid), 0);
    cycle(0, 0, 0, 1);
    chk("t5_pc0", s_pc, 32'h300);
    cycle(0, 0, 0, 1);
    chk("t5_pc1", s_pc, 32'h304);

    // wrap of fetch_pc past 2^32
    cycle(1, 32'hFFFF_FFF8, 0, 1);
    repeat (6) cycle(0, 0, 0, 1);

    // async reset between edges
    repeat (3) cycle(0, 0, 0, 0);
    #2 reset_n = 0;
    #1;
    chk("t6_valid_async", 32'(bus.out_valid), 0);
    chk("t6_occ_async", 32'(bus.occupancy), 0);
    chk("t6_en_async", 32'(bus.imem_enable), 0);
    @(posedge clk); #1;
    idle_inputs();
    reset_n = 1;
    model_reset();
    cycle(0, 0, 0, 1);
    chk("t6_restart_addr", s_addr, 32'h10);
    repeat (3) cycle(0, 0, 0, 1);

    // randomized traffic against the model
    begin
      bit rdy_bias;
      rdy_bias = 1;
      for (int i = 0; i < 3000; i++) begin
        bit rv, wt, rdy;
        logic [31:0] rpc;
        if (i % 64 == 0) rdy_bias = ($urandom_range(2) != 0);
        rv  = ($urandom_range(15) == 0);
        rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(3)) * 4)
                                       : ($urandom() & 32'hFFFF_FFFC);
        wt  = ($urandom_range(3) == 0);
        rdy = rdy_bias ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
        cycle(rv, rpc, wt, rdy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
